// File: rtl/pc_ctrl.sv
// Program-counter sequencer: resolves pipeline events into pc control, flushes and EPC.
// Optional PC_PERF_CNT_EN adds redirect and stall-cycle counter ports.
module pc_ctrl #(
    parameter int unsigned STALL_LIMIT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        BrTaken,
    input  logic        IsJump,
    input  logic        IsJr,
    input  logic        HazStall,
    input  logic        MemStall,
    input  logic        SiicReq,
    input  logic        RtiReq,
    input  logic        HaltReq,
    input  logic [15:0] ExPc,
    output logic        PcSel,
    output logic        RegJmp,
    output logic        Halt,
    output logic        SIIC,
    output logic        PcStall,
    output logic        EpcSel,
    output logic [15:0] Epc,
    output logic        FlushIfId,
    output logic        FlushIdEx,
    output logic        StallErr
`ifdef PC_PERF_CNT_EN
    ,
    output logic [15:0] RedirCnt,
    output logic [15:0] StallCyc
`endif
);

    typedef enum logic {RUN, HALTED} st_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    st_t              st;
    logic             in_handler;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             stall_raw;
    logic             row_siic;
    logic             row_halt;
    logic             row_rti;
    logic             flush;

    assign FlushIfId = flush;
    assign FlushIdEx = flush;

    always_comb begin
        PcSel     = 1'b0;
        RegJmp    = 1'b0;
        Halt      = 1'b0;
        SIIC      = 1'b0;
        PcStall   = 1'b0;
        EpcSel    = 1'b0;
        flush     = 1'b0;
        row_siic  = 1'b0;
        row_halt  = 1'b0;
        row_rti   = 1'b0;
        stall_raw = HazStall | MemStall;
        if (!rst) begin
            if (st == HALTED) begin
                Halt = 1'b1;
            end else if (SiicReq && !in_handler) begin
                row_siic = 1'b1;
                SIIC     = 1'b1;
                flush    = 1'b1;
            end else if (HaltReq) begin
                row_halt = 1'b1;
                Halt     = 1'b1;
            end else if (RtiReq && in_handler) begin
                row_rti = 1'b1;
                RegJmp  = 1'b1;
                EpcSel  = 1'b1;
                PcStall = stall_raw;
                flush   = !stall_raw;
            end else if (IsJr) begin
                // A stalled JR holds without flushing; upstream re-presents it next cycle.
                RegJmp  = 1'b1;
                PcStall = stall_raw;
                flush   = !stall_raw;
            end else if (BrTaken || IsJump) begin
                PcSel = 1'b1;
                flush = 1'b1;
            end else begin
                PcStall = stall_raw;
            end
        end
    end

    assign cnt_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= RUN;
            in_handler <= 1'b0;
            Epc        <= '0;
            stall_cnt  <= '0;
            StallErr   <= 1'b0;
        end else begin
            if (row_siic) begin
                Epc        <= ExPc + 16'd2;
                in_handler <= 1'b1;
            end
            if (row_halt) begin
                st <= HALTED;
            end
            if (row_rti && !PcStall) begin
                in_handler <= 1'b0;
            end
            if (PcStall) begin
                stall_cnt <= cnt_inc;
                if (cnt_inc >= LIMIT) begin
                    StallErr <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

`ifdef PC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RedirCnt <= '0;
            StallCyc <= '0;
        end else begin
            if (SIIC || PcSel || (RegJmp && !PcStall)) begin
                RedirCnt <= RedirCnt + 16'd1;
            end
            if (PcStall) begin
                StallCyc <= StallCyc + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios followed by random events
// checked against a rule-level reference model.
module tb_pc_ctrl;

    localparam int unsigned LIMIT = 4;

    localparam logic [7:0] EV_BR  = 8'h01;
    localparam logic [7:0] EV_JMP = 8'h02;
    localparam logic [7:0] EV_JR  = 8'h04;
    localparam logic [7:0] EV_HAZ = 8'h08;
    localparam logic [7:0] EV_MEM = 8'h10;
    localparam logic [7:0] EV_SI  = 8'h20;
    localparam logic [7:0] EV_RTI = 8'h40;
    localparam logic [7:0] EV_HLT = 8'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic        BrTaken, IsJump, IsJr, HazStall, MemStall, SiicReq, RtiReq, HaltReq;
    logic [15:0] ExPc;
    logic        PcSel, RegJmp, Halt, SIIC, PcStall, EpcSel, FlushIfId, FlushIdEx, StallErr;
    logic [15:0] Epc;

    always #5 clk = ~clk;

    pc_ctrl #(.STALL_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .BrTaken(BrTaken), .IsJump(IsJump), .IsJr(IsJr),
        .HazStall(HazStall), .MemStall(MemStall),
        .SiicReq(SiicReq), .RtiReq(RtiReq), .HaltReq(HaltReq),
        .ExPc(ExPc),
        .PcSel(PcSel), .RegJmp(RegJmp), .Halt(Halt), .SIIC(SIIC),
        .PcStall(PcStall), .EpcSel(EpcSel), .Epc(Epc),
        .FlushIfId(FlushIfId), .FlushIdEx(FlushIdEx), .StallErr(StallErr)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned nstep       = 0;

    // Reference model state
    bit          m_halted, m_inh, m_err;
    logic [15:0] m_epc;
    int unsigned m_run;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] flags();
        return {7'd0, PcSel, RegJmp, Halt, SIIC, PcStall, EpcSel, FlushIfId, FlushIdEx, StallErr};
    endfunction

    task automatic drive(input logic [7:0] ev, input logic [15:0] pc);
        BrTaken  = ev[0];
        IsJump   = ev[1];
        IsJr     = ev[2];
        HazStall = ev[3];
        MemStall = ev[4];
        SiicReq  = ev[5];
        RtiReq   = ev[6];
        HaltReq  = ev[7];
        ExPc     = pc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(EV_BR | EV_JR | EV_HAZ | EV_SI | EV_HLT, 16'h1234);
        #1;
        check("reset flags", flags(), 16'h0000);
        check("reset epc", Epc, 16'h0000);
        @(negedge clk);
        drive(8'h00, 16'h0000);
        rst = 1'b0;
        m_halted = 0; m_inh = 0; m_err = 0; m_epc = 16'h0000; m_run = 0;
    endtask

    task automatic step(input logic [7:0] ev, input logic [15:0] pc);
        bit stall, pcsel, regjmp, hlt, siic, pst, esel, fl;
        bit r_si, r_ht, r_rt;
        logic [15:0] exp;
        @(negedge clk);
        drive(ev, pc);
        #1;
        nstep++;
        stall = ev[3] | ev[4];
        {pcsel, regjmp, hlt, siic, pst, esel, fl} = '0;
        {r_si, r_ht, r_rt} = '0;
        if (m_halted) hlt = 1;
        else if (ev[5] && !m_inh) begin siic = 1; fl = 1; r_si = 1; end
        else if (ev[7]) begin hlt = 1; r_ht = 1; end
        else if (ev[6] && m_inh) begin regjmp = 1; esel = 1; pst = stall; fl = !stall; r_rt = 1; end
        else if (ev[2]) begin regjmp = 1; pst = stall; fl = !stall; end
        else if (ev[0] || ev[1]) begin pcsel = 1; fl = 1; end
        else pst = stall;
        exp = {7'd0, pcsel, regjmp, hlt, siic, pst, esel, fl, fl, m_err};
        check($sformatf("step%0d ev=%h flags", nstep, ev), flags(), exp);
        check($sformatf("step%0d epc", nstep), Epc, m_epc);
        if (r_si) begin m_epc = pc + 16'd2; m_inh = 1; end
        if (r_ht) m_halted = 1;
        if (r_rt && !stall) m_inh = 0;
        m_run = pst ? m_run + 1 : 0;
        if (m_run >= LIMIT) m_err = 1;
    endtask

    initial begin
        rst = 1'b0;
        drive(8'h00, 16'h0000);

        // Reset and idle
        do_reset();
        repeat (5) step(8'h00, 16'h0000);

        // SIIC entry, ignored re-entry, RTI return
        step(EV_SI, 16'h0040);
        step(EV_SI, 16'h0080);
        check("epc after siic", Epc, 16'h0042);
        step(EV_RTI, 16'h0100);
        step(EV_RTI, 16'h0102);

        // JR held by memory stall, then released; JR beats branch
        repeat (3) step(EV_JR | EV_MEM, 16'h0200);
        step(EV_JR, 16'h0200);
        step(EV_JR | EV_BR, 16'h0204);

        // Branch ignores hazard stall
        step(EV_BR | EV_HAZ, 16'h0300);

        // Halt is sticky until reset
        step(EV_HLT, 16'h0400);
        step(EV_SI, 16'h0402);
        step(EV_BR, 16'h0404);
        step(EV_JR | EV_HAZ, 16'h0406);
        do_reset();

        // Watchdog trip and EPC wrap
        repeat (LIMIT) step(EV_HAZ, 16'h0500);
        step(8'h00, 16'h0000);
        check("stallerr sticky", {15'd0, StallErr}, 16'h0001);
        step(EV_SI, 16'hFFFE);
        step(8'h00, 16'h0000);
        check("epc wrap", Epc, 16'h0000);

        // Random events, with occasional mid-stream resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ev;
            ev = 8'h00;
            for (int b = 0; b < 7; b++) ev[b] = ($urandom_range(0, 3) == 0);
            ev[7] = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 79) == 0) do_reset();
            step(ev, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
